// File: rtl/transmission8_sched.sv
// Round-robin burst scheduler for the shared 8-channel transmission path.
// Define TRANSMISSION8_GAP_EN to insert one idle GAP cycle after every burst.
module transmission8_sched #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [7:0]  iReq,
    input  logic [23:0] iDest,
    output logic [7:0]  oGrant,
    output logic [2:0]  oSrcSel,
    output logic [2:0]  oDstSel,
    output logic        oValid,
    output logic        oDone
);

    // state | meaning
    // IDLE  | no burst in progress, outputs cleared
    // XFER  | burst owner granted, one beat per cycle
    // GAP   | one dead cycle after a burst (GAP build only)
    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

`ifdef TRANSMISSION8_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t            state_q;
    logic [2:0]        rr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [7:0]        grant_q;
    logic [2:0]        src_q;
    logic [2:0]        dst_q;
    logic              valid_q;
    logic              done_q;

    logic              last_beat;
    logic              any_req;
    logic              start_burst;
    logic [2:0]        arb_ptr;
    logic [2:0]        idx;
    logic [2:0]        win_src;
    logic [2:0]        win_dst;

    always_comb begin
        last_beat = (state_q == XFER) && (cnt_q == LAST_BEAT);
        // On a last beat the pointer register has not moved yet, so search from owner+1.
        arb_ptr   = last_beat ? (src_q + 3'd1) : rr_q;
        any_req   = 1'b0;
        idx       = '0;
        win_src   = '0;
        win_dst   = '0;
        for (int i = 0; i < 8; i++) begin
            idx = arb_ptr + 3'(i);
            if (!any_req && iReq[idx]) begin
                any_req = 1'b1;
                win_src = idx;
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (3'(j) == win_src) begin
                win_dst = iDest[3*j +: 3];
            end
        end
        start_burst = any_req && ((state_q != XFER) || (last_beat && !GAP_EN));
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (last_beat) begin
                rr_q <= src_q + 3'd1;
            end
            if (start_burst) begin
                state_q <= XFER;
                cnt_q   <= '0;
                grant_q <= 8'(1) << win_src;
                src_q   <= win_src;
                dst_q   <= win_dst;
                valid_q <= 1'b1;
                done_q  <= (LAST_BEAT == '0);
            end else if ((state_q == XFER) && !last_beat) begin
                cnt_q  <= cnt_q + CNT_W'(1);
                done_q <= ((cnt_q + CNT_W'(1)) == LAST_BEAT);
            end else begin
                state_q <= (last_beat && GAP_EN) ? GAP : IDLE;
                cnt_q   <= '0;
                grant_q <= '0;
                src_q   <= '0;
                dst_q   <= '0;
                valid_q <= 1'b0;
                done_q  <= 1'b0;
            end
        end
    end

    assign oGrant  = grant_q;
    assign oSrcSel = src_q;
    assign oDstSel = dst_q;
    assign oValid  = valid_q;
    assign oDone   = done_q;

endmodule

// File: tb/tb_transmission8_sched.sv
// Self-checking bench for transmission8_sched: expected per-cycle outputs are
// queued as stimulus is planned and compared on every falling edge.
module tb_transmission8_sched;

    localparam int BL = 4;
`ifdef TRANSMISSION8_GAP_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  req;
    logic [23:0] dest;
    logic [7:0]  grant;
    logic [2:0]  src_sel;
    logic [2:0]  dst_sel;
    logic        valid;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] obs;
    logic [15:0] expv;

    transmission8_sched #(.BURST_LEN(BL), .CNT_W(4)) dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iReq    (req),
        .iDest   (dest),
        .oGrant  (grant),
        .oSrcSel (src_sel),
        .oDstSel (dst_sel),
        .oValid  (valid),
        .oDone   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    // Packed expectation: {grant, src, dst, valid, done}
    function automatic logic [15:0] beat(input int s, input int d, input bit last);
        return {8'(1 << s), 3'(s), 3'(d), 1'b1, last};
    endfunction

    task automatic push_burst(input int s, input int d);
        for (int b = 0; b < BL; b++) exp_q.push_back(beat(s, d, b == BL - 1));
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(16'h0000);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        dest  = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int j;
        rst_n = 1'b0;
        req   = '0;
        dest  = '0;
        push_idle(12);
        j = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            j++;
            obs  = {grant, src_sel, dst_sel, valid, done};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset cyc %0d: got grant=%h src=%0d dst=%0d valid=%b done=%b, need grant=%h src=%0d dst=%0d valid=%b done=%b",
                         j, obs[15:8], obs[7:5], obs[4:2], obs[1], obs[0], expv[15:8], expv[7:5], expv[4:2], expv[1], expv[0]);
            end
            if (j == 1) rst_n = 1'b1;
        end
    endtask

    task automatic test_single();
        int j;
        req  = 8'h08;
        dest = 24'd5 << 9;
        push_burst(3, 5);
        push_idle(G + 2);
        j = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            j++;
            obs  = {grant, src_sel, dst_sel, valid, done};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL single cyc %0d: got grant=%h src=%0d dst=%0d valid=%b done=%b, need grant=%h src=%0d dst=%0d valid=%b done=%b",
                         j, obs[15:8], obs[7:5], obs[4:2], obs[1], obs[0], expv[15:8], expv[7:5], expv[4:2], expv[1], expv[0]);
            end
            if (j == 1) req = 8'h00;
        end
    endtask

    task automatic test_fairness();
        int j;
        apply_reset();
        for (int n = 0; n < 8; n++) dest[3*n +: 3] = 3'(7 - n);
        req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            push_burst(n % 8, 7 - (n % 8));
            push_idle(G);
        end
        j = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            j++;
            obs  = {grant, src_sel, dst_sel, valid, done};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL fairness cyc %0d: got grant=%h src=%0d dst=%0d valid=%b done=%b, need grant=%h src=%0d dst=%0d valid=%b done=%b",
                         j, obs[15:8], obs[7:5], obs[4:2], obs[1], obs[0], expv[15:8], expv[7:5], expv[4:2], expv[1], expv[0]);
            end
        end
        req = 8'h00;
    endtask

    task automatic test_wrap();
        int j;
        apply_reset();
        dest = (24'd2 << 15) | 24'd4;
        req  = 8'h20;
        push_burst(5, 2);
        push_idle(G + 1);
        push_burst(0, 4);
        push_idle(G);
        push_burst(5, 2);
        push_idle(G + 1);
        j = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            j++;
            obs  = {grant, src_sel, dst_sel, valid, done};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL wrap cyc %0d: got grant=%h src=%0d dst=%0d valid=%b done=%b, need grant=%h src=%0d dst=%0d valid=%b done=%b",
                         j, obs[15:8], obs[7:5], obs[4:2], obs[1], obs[0], expv[15:8], expv[7:5], expv[4:2], expv[1], expv[0]);
            end
            if (j == 1) req = 8'h00;
            if (j == 5 + G) req = 8'h21;
            if (j == 10 + 2*G) req = 8'h00;
        end
    endtask

    task automatic test_freeze();
        int j;
        apply_reset();
        req  = 8'h04;
        dest = 24'd6 << 6;
        push_burst(2, 6);
        push_idle(G + 2);
        j = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            j++;
            obs  = {grant, src_sel, dst_sel, valid, done};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL freeze cyc %0d: got grant=%h src=%0d dst=%0d valid=%b done=%b, need grant=%h src=%0d dst=%0d valid=%b done=%b",
                         j, obs[15:8], obs[7:5], obs[4:2], obs[1], obs[0], expv[15:8], expv[7:5], expv[4:2], expv[1], expv[0]);
            end
            if (j == 1) begin
                req  = 8'h00;
                dest = 24'hFFFFFF;
            end
        end
    endtask

    // Reset mid-burst must abort without oDone and return the pointer to 0.
    task automatic test_reset_mid();
        int j;
        apply_reset();
        dest = (24'd2 << 12) | (24'd1 << 9) | (24'd3 << 3);
        req  = 8'h08;
        push_burst(3, 1);
        push_idle(G + 1);
        exp_q.push_back(beat(1, 3, 1'b0));
        exp_q.push_back(beat(1, 3, 1'b0));
        push_idle(2);
        push_burst(1, 3);
        push_idle(G + 1);
        j = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            j++;
            obs  = {grant, src_sel, dst_sel, valid, done};
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got grant=%h src=%0d dst=%0d valid=%b done=%b, need grant=%h src=%0d dst=%0d valid=%b done=%b",
                         j, obs[15:8], obs[7:5], obs[4:2], obs[1], obs[0], expv[15:8], expv[7:5], expv[4:2], expv[1], expv[0]);
            end
            if (j == 1) req = 8'h00;
            if (j == 5 + G) req = 8'h02;
            if (j == 6 + G) req = 8'h00;
            if (j == 7 + G) rst_n = 1'b0;
            if (j == 8 + G) rst_n = 1'b1;
            if (j == 9 + G) req = 8'h12;
            if (j == 10 + G) req = 8'h00;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        dest  = '0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_freeze();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transmission8_sched.md
Name: transmission8_sched

Overview:
- Round-robin scheduler for the shared 8-channel transmission path, which takes 8 data sources, a 3-bit select and 8 destinations.
- Arbitrates among 8 requesting sources and grants one source at a time for a fixed-length burst.
- Drives the path's source/destination select lines plus valid/done strobes.
- Sits between the requester agents and the transmission datapath; the datapath itself is unchanged.

Parameters:
- BURST_LEN, 4, beats per granted burst; legal range 1..16.
- CNT_W, 4, width of the beat counter; must satisfy 2**CNT_W >= BURST_LEN.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst_n  input  1  reset, synchronous, active-low.
- iReq  input  8  per-source request; bit n = source n wants the path.
- iDest  input  24  per-source destination; iDest[3n+2:3n] = destination channel of source n.
- oGrant  output  8  one-hot grant to the current burst owner; 0 when idle.
- oSrcSel  output  3  source select to the datapath (maps to A,B,C = bit2,bit1,bit0).
- oDstSel  output  3  destination select to the datapath.
- oValid  output  1  high on every beat of a granted burst.
- oDone  output  1  single-cycle pulse on the last beat of a burst.

Behaviour:
- Reset, sampled when iRst_n = 0 at a rising edge:
  - state = IDLE, rr pointer = 0, beat counter = 0.
  - oGrant = 0, oSrcSel = 0, oDstSel = 0, oValid = 0, oDone = 0.
  - Reset mid-burst aborts the burst immediately; no oDone is issued.
- States: IDLE, XFER, GAP. GAP exists only with the optional feature.
- Arbitration:
  - Winner = first n with iReq[n] = 1, searching from the rr pointer upward and wrapping 7 -> 0.
  - Arbitration is combinational on the current iReq and rr pointer.
  - The result is registered into oGrant/oSrcSel/oDstSel.
- IDLE:
  - No request: stay in IDLE; outputs hold their reset values.
  - Any iReq bit set at edge k: from edge k+1, state = XFER, oGrant = onehot(winner), oSrcSel = winner, oDstSel = iDest slice of winner (captured at edge k), oValid = 1, counter = 0.
  - Latency from request to first valid beat: 1 cycle.
- XFER:
  - oValid = 1; counter increments each cycle.
  - oDstSel is frozen for the whole burst; iDest changes mid-burst are ignored.
  - Deasserting iReq mid-burst does not shorten the burst; all BURST_LEN beats complete.
  - Last beat (counter = BURST_LEN-1):
    - oDone = 1 in the same cycle.
    - rr pointer <= (winner+1) mod 8.
  - Next state without the feature: if any iReq is set on the last beat, re-arbitrate with the updated pointer and start the next burst on the very next cycle (back-to-back, no bubble). Otherwise go to IDLE and clear oGrant/oSrcSel/oDstSel/oValid.
  - A winner still requesting after its burst is eligible again, but only after all other requesters at or after the pointer.
- BURST_LEN = 1: each burst is one beat, and oDone = oValid.
- The counter never exceeds BURST_LEN-1; it wraps to 0 when a new burst starts.
- Fairness: with all 8 requesting continuously, the grant order is 0,1,...,7,0,... with no source skipped.

Optional Feature:
- Macro: TRANSMISSION8_GAP_EN.
- Defined:
  - After every last beat, the FSM enters GAP for exactly 1 cycle: oValid = 0, oGrant = 0, selects = 0.
  - Arbitration happens in GAP using the updated pointer; the next XFER starts the cycle after GAP.
  - A request present in GAP is granted with no further delay.
- Undefined: GAP is absent and bursts run back-to-back as described above.

Test Plan:
1. Reset, then iReq = 8'h00 for 10 cycles -> oValid, oGrant, oDone all stay 0.
2. iReq = 8'h08 for 1 cycle, iDest[11:9] = 3'd5, BURST_LEN = 4 -> from the next cycle, oGrant = 8'h08, oSrcSel = 3, oDstSel = 5, oValid high for 4 cycles, oDone on beat 4, then IDLE.
3. iReq = 8'hFF held, no GAP -> oSrcSel sequence 0,1,...,7,0 with each value held 4 cycles, oValid continuously high, oDone every 4th cycle.
4. rr pointer = 6 (after granting 5), iReq = 8'h21 -> source 0 is granted first (wrap past 6,7), then source 5.
5. Change iDest and drop iReq mid-burst -> oDstSel unchanged, burst still runs 4 beats, oDone asserted once.
6. iRst_n = 0 for 1 cycle at beat 2 -> next cycle all outputs 0 and no oDone. With TRANSMISSION8_GAP_EN and iReq = 8'hFF -> one oValid = 0 cycle between consecutive bursts.
